pwm_multi_gen: RTL and testbench

//  Multi-channel, register-programmed PWM generator; next generation of the single-channel

---
 rtl/pwm_multi_gen.sv | 125 ++++++++++++
 tb/tb_pwm_multi_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with a shared timebase counter.
// Config writes land in shadow registers and are promoted to active registers at period boundaries.
module pwm_multi_gen #(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 16,
  parameter logic [CNT_W-1:0]  DEF_PERIOD = CNT_W'(49_999),
  parameter logic [NUM_CH-1:0] INVERT     = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_CH+2)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]            cfg_wdata,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        period_start
);

  localparam int ADDR_W = $clog2(NUM_CH + 2);
  localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] MODE_ADDR   = ADDR_W'(NUM_CH + 1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [CNT_W-1:0]  period_sh;
  logic              mode_sh;
  logic [CNT_W-1:0]  duty_sh [NUM_CH];

  logic [CNT_W-1:0]  period_act;
  logic              mode_act;
  logic [CNT_W-1:0]  duty_act [NUM_CH];

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  dir_t              dir;
  dir_t              dir_nxt;
  logic              wrap;
  logic [NUM_CH-1:0] raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh <= DEF_PERIOD;
      mode_sh   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == PERIOD_ADDR) period_sh <= cfg_wdata;
      if (cfg_addr == MODE_ADDR)   mode_sh   <= cfg_wdata[0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_addr == ADDR_W'(i)) duty_sh[i] <= cfg_wdata;
      end
    end
  end

  // Center mode turns around at P; a period of 0 or 1 has no down leg and wraps straight to 0.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    wrap    = 1'b0;
    if (!mode_act) begin
      if (cnt >= period_act) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else if (dir == DIR_UP) begin
      if (cnt >= period_act) begin
        if (period_act <= CNT_W'(1)) begin
          cnt_nxt = '0;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          dir_nxt = DIR_DOWN;
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      if (cnt <= CNT_W'(1)) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) raw[i] = (cnt < duty_act[i]);
  end

  // While disabled the active set tracks the shadow set, so enabling starts a clean period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      period_act   <= DEF_PERIOD;
      mode_act     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
      pwm_out      <= INVERT;
      period_start <= 1'b0;
    end else if (!en) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      period_act   <= period_sh;
      mode_act     <= mode_sh;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      pwm_out      <= INVERT;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      pwm_out      <= raw ^ INVERT;
      period_start <= (cnt == '0);
      if (wrap) begin
        period_act <= period_sh;
        mode_act   <= mode_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: phase-index reference model plus directed literal checks.
module tb_pwm_multi_gen;

  localparam int          NCH = 4;
  localparam int          CW  = 16;
  localparam logic [3:0]  INV = 4'b0010;
  localparam logic [15:0] DEFP = 16'd11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [3:0]  pwm_out;
  logic        period_start;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  pwm_multi_gen #(
    .NUM_CH(NCH), .CNT_W(CW), .DEF_PERIOD(DEFP), .INVERT(INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period as a plain index k, cnt derived arithmetically.
  int unsigned m_k;
  int unsigned m_p, m_p_sh;
  int unsigned m_d [NCH];
  int unsigned m_d_sh [NCH];
  bit          m_mode, m_mode_sh;
  logic [3:0]  exp_pwm;
  logic        exp_ps;

  function automatic int unsigned period_len(input int unsigned p, input bit center);
    if (p == 0) return 1;
    return center ? 2 * p : p + 1;
  endfunction

  function automatic int unsigned cnt_at(input int unsigned k, input int unsigned p, input bit center);
    if (!center || k <= p) return k;
    return 2 * p - k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_p = DEFP; m_p_sh = DEFP; m_mode = 0; m_mode_sh = 0;
      for (int i = 0; i < NCH; i++) begin m_d[i] = 0; m_d_sh[i] = 0; end
      exp_pwm = INV; exp_ps = 1'b0;
    end else begin
      if (!en) begin
        exp_pwm = INV; exp_ps = 1'b0; m_k = 0;
        m_p = m_p_sh; m_mode = m_mode_sh;
        for (int i = 0; i < NCH; i++) m_d[i] = m_d_sh[i];
      end else begin
        int unsigned c;
        c = cnt_at(m_k, m_p, m_mode);
        for (int i = 0; i < NCH; i++) exp_pwm[i] = (m_d[i] > c) ^ INV[i];
        exp_ps = (m_k == 0);
        m_k++;
        if (m_k >= period_len(m_p, m_mode)) begin
          m_k = 0; m_p = m_p_sh; m_mode = m_mode_sh;
          for (int i = 0; i < NCH; i++) m_d[i] = m_d_sh[i];
        end
      end
      if (cfg_we) begin
        if (cfg_addr < 3'(NCH)) m_d_sh[cfg_addr] = cfg_wdata;
        else if (cfg_addr == 3'(NCH)) m_p_sh = cfg_wdata;
        else if (cfg_addr == 3'(NCH + 1)) m_mode_sh = cfg_wdata[0];
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        bad++;
        $display("[TB] FAIL model_cycle t=%0t pwm_out=%b expected=%b period_start=%b expected=%b",
                 $time, pwm_out, exp_pwm, period_start, exp_ps);
      end
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic write_cfg(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_wdata = 16'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic configure(input int p, input int mode, input int d0, input int d1,
                           input int d2, input int d3);
    en = 1'b0;
    write_cfg(4, p); write_cfg(5, mode);
    write_cfg(0, d0); write_cfg(1, d1); write_cfg(2, d2); write_cfg(3, d3);
    @(negedge clk); @(negedge clk);
    en = 1'b1;
  endtask

  task automatic sync_period(input string name);
    int n = 0;
    while (period_start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (period_start !== 1'b1) begin
      total++; bad++;
      $display("[TB] FAIL %s no period_start within 200 cycles", name);
    end
  endtask

  // Counts output-level high cycles per channel over n cycles, optionally writing at cycle wr_j.
  task automatic measure(input int n, input int wr_j, input int addr, input int data,
                         output int h0, output int h1, output int h2, output int h3,
                         output int ps);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; ps = 0;
    for (int j = 0; j < n; j++) begin
      cfg_we = (j == wr_j); cfg_addr = 3'(addr); cfg_wdata = 16'(data);
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]); h3 += int'(pwm_out[3]);
      ps += int'(period_start);
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int a;
      en = ($urandom_range(0, 99) < 97);
      cfg_we = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 7);
      cfg_addr = 3'(a);
      if (a == 4) cfg_wdata = 16'($urandom_range(0, 20));
      else if (a == 5) cfg_wdata = 16'($urandom);
      else if ($urandom_range(0, 9) == 0) cfg_wdata = 16'hFFFF;
      else cfg_wdata = 16'($urandom_range(0, 25));
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    int h0, h1, h2, h3, ps;
    rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check_val("reset_pwm_out", int'(pwm_out), int'(INV));
    check_val("reset_period_start", int'(period_start), 0);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Default period after reset: 12 cycles, all duties zero.
    en = 1'b1;
    sync_period("default_sync");
    measure(24, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("default_ps_per_24", ps, 2);
    check_val("default_ch0_high", h0, 0);
    check_val("default_ch1_inverted_high", h1, 24);

    // Edge mode P=9: ch0 duty 3, inverted ch1 duty 3, ch2 duty 10, ch3 duty 65535.
    configure(9, 0, 3, 3, 10, 65535);
    sync_period("edge_sync");
    measure(10, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("edge_ch0_high", h0, 3);
    check_val("edge_ch1_inv_high", h1, 7);
    check_val("edge_ch2_full", h2, 10);
    check_val("edge_ch3_full", h3, 10);
    check_val("edge_ps_per_10", ps, 1);

    // Shadow update mid-period, then a write landing on the boundary edge.
    write_cfg(1, 0);
    sync_period("update_sync");
    measure(10, 4, 0, 7, h0, h1, h2, h3, ps);
    check_val("update_cur_period_ch0", h0, 3);
    measure(10, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("update_next_period_ch0", h0, 7);
    check_val("duty0_inverted_ch1_const", h1, 10);
    measure(10, 8, 0, 2, h0, h1, h2, h3, ps);
    check_val("boundary_write_cur_ch0", h0, 7);
    measure(10, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("boundary_write_deferred_ch0", h0, 7);
    measure(10, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("boundary_write_applied_ch0", h0, 2);

    // Center mode P=4, duty0=2: 8-cycle period, 3 high cycles centered on cnt=0.
    configure(4, 1, 2, 0, 10, 65535);
    sync_period("center_sync");
    check_val("center_ch0_at_cnt0", int'(pwm_out[0]), 1);
    measure(16, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("center_ch0_high_16", h0, 6);
    check_val("center_ps_per_16", ps, 2);

    // Disabled: outputs idle at INVERT, no period_start.
    en = 1'b0;
    @(negedge clk); @(negedge clk);
    check_val("disabled_pwm_out", int'(pwm_out), int'(INV));
    check_val("disabled_period_start", int'(period_start), 0);

    // Asynchronous reset mid-period, then defaults after release.
    configure(9, 0, 5, 5, 5, 5);
    repeat (13) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_pwm_out", int'(pwm_out), int'(INV));
    check_val("async_reset_period_start", int'(period_start), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    sync_period("post_reset_sync");
    measure(24, -1, 0, 0, h0, h1, h2, h3, ps);
    check_val("post_reset_ps_per_24", ps, 2);
    check_val("post_reset_ch0_high", h0, 0);

    apply_stimulus(4000);
    en = 1'b1;
    repeat (20) @(negedge clk);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
